// File: rtl/blit_cmdlist_fetch_pkg.sv
// ============================================================================
// blit_cmdlist_fetch_pkg : register map, CONTROL bits and FSM states (rev 1.0)
// ============================================================================
`default_nettype none

package blit_cmdlist_fetch_pkg;

    localparam logic [1:0] CMDL_REG_BASE    = 2'd0;
    localparam logic [1:0] CMDL_REG_LENGTH  = 2'd1;
    localparam logic [1:0] CMDL_REG_CONTROL = 2'd2;

    localparam int CTRL_ABORT_BIT = 0;
    localparam int CTRL_PRIV_BIT  = 1;

    localparam int ADDR_W = 26;

    typedef enum logic [2:0] {
        CMDL_IDLE     = 3'd0,
        CMDL_REQ      = 3'd1,
        CMDL_BURST    = 3'd2,
        CMDL_WAITROOM = 3'd3,
        CMDL_DRAIN    = 3'd4
    } cmdl_state_e;

endpackage

`default_nettype wire

// File: rtl/blit_cmdlist_fetch_fifo.sv
// ============================================================================
// blit_cmdlist_fetch_fifo : show-ahead sync FIFO with count and flush (rev 1.0)
// ============================================================================
`default_nettype none

module blit_cmdlist_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_full;
    logic             w_do_rd;
    logic             w_do_wr;

    assign w_full  = (count_q == CW'(DEPTH));
    assign w_do_rd = rd_en_i && (count_q != '0) && !flush_i;
    // A read in the same cycle frees a slot, so a write at full is still legal.
    assign w_do_wr = wr_en_i && (!w_full || w_do_rd) && !flush_i;

    assign overflow_o = wr_en_i && w_full && !w_do_rd && !flush_i;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (w_do_rd && !w_do_wr) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/blit_cmdlist_fetch.sv
// ============================================================================
// blit_cmdlist_fetch : command-list DMA from SDRAM into the blitter (rev 1.0)
// ============================================================================
`default_nettype none

module blit_cmdlist_fetch
    import blit_cmdlist_fetch_pkg::*;
#(
    parameter int BURST_WORDS = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int SLOT_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hwregs_cmdl_write_i,
    input  logic [1:0]  hwregs_cmdl_reg_i,
    input  logic [31:0] hwregs_cmdl_wdata_i,
    input  logic        hwregs_cmdl_privaledge_i,
    output logic        cmdl_busy_o,
    output logic        cmdl_done_o,
    output logic [15:0] cmdl_remaining_o,
    output logic        sdram_request_o,
    output logic [25:0] sdram_address_o,
    input  logic        sdram_ready_i,
    input  logic        sdram_rvalid_i,
    input  logic [31:0] sdram_rdata_i,
    input  logic [25:0] sdram_raddress_i,
    input  logic        sdram_complete_i,
    input  logic [9:0]  blit_fifo_slots_free_i,
    output logic        hwregs_blit_valid_o,
    output logic [31:0] hwregs_blit_command_o,
    output logic        hwregs_blit_privaledge_o,
    output logic        fault_detected_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    cmdl_state_e state_q, state_d;

    logic [25:0] base_q;
    logic [15:0] length_q;
    logic        priv_q;
    logic [25:0] req_addr_q;
    logic [25:0] exp_addr_q;
    logic [16:0] rx_idx_q;
    logic [16:0] req_words_q;
    logic [15:0] remaining_q;
    logic        aborting_q;
    logic        done_q;
    logic        valid_q;
    logic [31:0] command_q;
    logic        fault_q;

    logic          w_busy, w_wr_base, w_wr_len, w_wr_ctrl, w_abort, w_start;
    logic          w_accept, w_in_burst, w_fifo_wr, w_pop, w_more, w_room;
    logic          w_fault_ev, w_done_ev;
    logic          w_fifo_empty, w_fifo_overflow;
    logic [31:0]   w_fifo_rdata;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_free;
    logic          w_unused;

    assign w_busy     = (state_q != CMDL_IDLE);
    assign w_wr_base  = hwregs_cmdl_write_i && (hwregs_cmdl_reg_i == CMDL_REG_BASE) && !w_busy;
    assign w_wr_len   = hwregs_cmdl_write_i && (hwregs_cmdl_reg_i == CMDL_REG_LENGTH) && !w_busy;
    assign w_wr_ctrl  = hwregs_cmdl_write_i && (hwregs_cmdl_reg_i == CMDL_REG_CONTROL);
    assign w_abort    = w_wr_ctrl && hwregs_cmdl_wdata_i[CTRL_ABORT_BIT] && w_busy;
    assign w_start    = w_wr_len && (hwregs_cmdl_wdata_i[15:0] != 16'd0);
    assign w_accept   = (state_q == CMDL_REQ) && sdram_ready_i;
    assign w_in_burst = (state_q == CMDL_BURST);
    assign w_more     = (req_words_q < {1'b0, length_q});

    // Overfetched words past LENGTH and anything arriving during an abort are dropped.
    assign w_fifo_wr  = sdram_rvalid_i && w_in_burst && !aborting_q && !w_abort &&
                        (rx_idx_q < {1'b0, length_q});
    assign w_pop      = !w_fifo_empty && !aborting_q && !w_abort &&
                        (blit_fifo_slots_free_i >= 10'(SLOT_MARGIN));

    // Room check counts a word landing this cycle but ignores a pop (conservative).
    assign w_free     = CW'(FIFO_DEPTH) - w_fifo_count - {{(CW-1){1'b0}}, w_fifo_wr};
    assign w_room     = (w_free >= CW'(BURST_WORDS));

    assign w_fault_ev = (sdram_rvalid_i && !w_in_burst) ||
                        (sdram_rvalid_i && w_in_burst && (sdram_raddress_i != exp_addr_q)) ||
                        w_fifo_overflow;

    assign w_unused   = ^{hwregs_cmdl_wdata_i[31:26]};

    blit_cmdlist_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (w_abort),
        .wr_en_i    (w_fifo_wr),
        .wr_data_i  (sdram_rdata_i),
        .rd_en_i    (w_pop),
        .rd_data_o  (w_fifo_rdata),
        .count_o    (w_fifo_count),
        .empty_o    (w_fifo_empty),
        .overflow_o (w_fifo_overflow)
    );

    always_comb begin
        state_d   = state_q;
        w_done_ev = 1'b0;
        case (state_q)
            CMDL_IDLE: begin
                if (w_start) begin
                    state_d = CMDL_REQ;
                end else if (w_wr_len) begin
                    w_done_ev = 1'b1;
                end
            end
            CMDL_REQ: begin
                // An abort here still waits for the accept so the arbiter stays in sync.
                if (sdram_ready_i) begin
                    state_d = CMDL_BURST;
                end
            end
            CMDL_BURST: begin
                if (sdram_complete_i) begin
                    if (aborting_q || w_abort) begin
                        state_d = CMDL_IDLE;
                    end else if (w_more) begin
                        state_d = w_room ? CMDL_REQ : CMDL_WAITROOM;
                    end else begin
                        state_d = CMDL_DRAIN;
                    end
                end
            end
            CMDL_WAITROOM: begin
                if (w_abort) begin
                    state_d = CMDL_IDLE;
                end else if (w_room) begin
                    state_d = CMDL_REQ;
                end
            end
            CMDL_DRAIN: begin
                if (w_abort) begin
                    state_d = CMDL_IDLE;
                end else if (w_fifo_empty && (remaining_q == 16'd0)) begin
                    state_d   = CMDL_IDLE;
                    w_done_ev = 1'b1;
                end
            end
            default: state_d = CMDL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CMDL_IDLE;
            base_q      <= '0;
            length_q    <= '0;
            priv_q      <= 1'b0;
            req_addr_q  <= '0;
            exp_addr_q  <= '0;
            rx_idx_q    <= '0;
            req_words_q <= '0;
            remaining_q <= '0;
            aborting_q  <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            command_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            aborting_q <= (state_d != CMDL_IDLE) && (aborting_q || w_abort);
            done_q     <= w_done_ev;
            valid_q    <= w_pop;
            fault_q    <= fault_q | w_fault_ev;

            if (w_wr_base) begin
                base_q <= {hwregs_cmdl_wdata_i[25:2], 2'b00};
            end
            if (w_wr_ctrl && !w_busy) begin
                priv_q <= hwregs_cmdl_wdata_i[CTRL_PRIV_BIT] & hwregs_cmdl_privaledge_i;
            end
            if (w_wr_len) begin
                length_q <= hwregs_cmdl_wdata_i[15:0];
            end

            if (w_start) begin
                req_addr_q  <= base_q;
                req_words_q <= '0;
            end else if (w_accept) begin
                req_addr_q  <= req_addr_q + 26'(4 * BURST_WORDS);
                req_words_q <= req_words_q + 17'(BURST_WORDS);
            end

            if (w_start) begin
                exp_addr_q <= base_q;
                rx_idx_q   <= '0;
            end else if (sdram_rvalid_i && w_in_burst) begin
                exp_addr_q <= exp_addr_q + 26'd4;
                rx_idx_q   <= rx_idx_q + 17'd1;
            end

            if (w_wr_len) begin
                remaining_q <= hwregs_cmdl_wdata_i[15:0];
            end else if (w_abort) begin
                remaining_q <= '0;
            end else if (w_pop) begin
                remaining_q <= remaining_q - 16'd1;
            end

            if (w_pop) begin
                command_q <= w_fifo_rdata;
            end
        end
    end

    assign cmdl_busy_o              = w_busy;
    assign cmdl_done_o              = done_q;
    assign cmdl_remaining_o         = remaining_q;
    assign sdram_request_o          = (state_q == CMDL_REQ);
    assign sdram_address_o          = req_addr_q;
    assign hwregs_blit_valid_o      = valid_q;
    assign hwregs_blit_command_o    = command_q;
    assign hwregs_blit_privaledge_o = priv_q;
    assign fault_detected_o         = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_blit_cmdlist_fetch.sv
// ============================================================================
// tb_blit_cmdlist_fetch : self-checking bench with SDRAM/blitter models (rev 1.0)
// ============================================================================
`default_nettype none

module tb_blit_cmdlist_fetch;

    localparam int BW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmdl_write = 1'b0;
    logic [1:0]  cmdl_reg = 2'd0;
    logic [31:0] cmdl_wdata = '0;
    logic        cmdl_priv = 1'b0;
    logic        busy, done;
    logic [15:0] remaining;
    logic        sdram_request;
    logic [25:0] sdram_address;
    logic        sdram_ready = 1'b0;
    logic        sdram_rvalid = 1'b0;
    logic [31:0] sdram_rdata = '0;
    logic [25:0] sdram_raddress = '0;
    logic        sdram_complete = 1'b0;
    logic [9:0]  slots_free = 10'd512;
    logic        blit_valid;
    logic [31:0] blit_command;
    logic        blit_priv;
    logic        fault;

    int n_checks = 0;
    int n_err = 0;

    logic [25:0] req_log[$];
    logic [31:0] push_log[$];
    logic        push_priv[$];
    int          done_cnt = 0;
    int          word_ctr = 0;
    int          burst_word = 0;
    int          corrupt_at = -1;
    int          slots_mode = 0;

    always #5 clk = ~clk;

    blit_cmdlist_fetch dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .hwregs_cmdl_write_i      (cmdl_write),
        .hwregs_cmdl_reg_i        (cmdl_reg),
        .hwregs_cmdl_wdata_i      (cmdl_wdata),
        .hwregs_cmdl_privaledge_i (cmdl_priv),
        .cmdl_busy_o              (busy),
        .cmdl_done_o              (done),
        .cmdl_remaining_o         (remaining),
        .sdram_request_o          (sdram_request),
        .sdram_address_o          (sdram_address),
        .sdram_ready_i            (sdram_ready),
        .sdram_rvalid_i           (sdram_rvalid),
        .sdram_rdata_i            (sdram_rdata),
        .sdram_raddress_i         (sdram_raddress),
        .sdram_complete_i         (sdram_complete),
        .blit_fifo_slots_free_i   (slots_free),
        .hwregs_blit_valid_o      (blit_valid),
        .hwregs_blit_command_o    (blit_command),
        .hwregs_blit_privaledge_o (blit_priv),
        .fault_detected_o         (fault)
    );

    // Contents of simulated SDRAM: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [25:0] a);
        return 32'hC0DE0000 ^ {6'b0, a} ^ {a[18:0], 13'b0};
    endfunction

    // SDRAM read port: random accept delay, BW words with random gaps, then complete.
    initial begin
        logic [25:0] a, wa;
        forever begin
            @(negedge clk);
            if (rst_n && sdram_request) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                a = sdram_address;
                req_log.push_back(a);
                sdram_ready = 1'b1;
                @(negedge clk);
                sdram_ready = 1'b0;
                for (int i = 0; i < BW; i++) begin
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    wa = a + 26'(4 * i);
                    sdram_rvalid   = 1'b1;
                    sdram_rdata    = mem_word(wa);
                    sdram_raddress = (word_ctr == corrupt_at) ? wa + 26'd4 : wa;
                    word_ctr++;
                    burst_word = i + 1;
                    @(negedge clk);
                    sdram_rvalid = 1'b0;
                end
                sdram_complete = 1'b1;
                @(negedge clk);
                sdram_complete = 1'b0;
                burst_word = 0;
            end
        end
    end

    // Blitter FIFO occupancy: 0 = plenty, 1 = held at one slot, 2 = random throttling.
    initial begin
        forever begin
            @(negedge clk);
            case (slots_mode)
                1:       slots_free = 10'd1;
                2:       slots_free = ($urandom_range(0, 2) == 0) ? 10'd1 : 10'd512;
                default: slots_free = 10'd512;
            endcase
        end
    end

    always @(negedge clk) begin
        if (blit_valid) begin
            push_log.push_back(blit_command);
            push_priv.push_back(blit_priv);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [31:0] d, input logic p);
        @(negedge clk);
        cmdl_write = 1'b1;
        cmdl_reg   = r;
        cmdl_wdata = d;
        cmdl_priv  = p;
        @(negedge clk);
        cmdl_write = 1'b0;
        cmdl_priv  = 1'b0;
    endtask

    task automatic start_list(input logic [25:0] base, input logic [15:0] len,
                              input logic privw, input logic privok);
        wr_reg(2'd0, {6'b0, base}, 1'b0);
        wr_reg(2'd2, {30'b0, privw, 1'b0}, privok);
        wr_reg(2'd1, {16'b0, len}, 1'b0);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int c = 0;
        while (done_cnt == d0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", budget);
        end
        repeat (6) @(negedge clk);
    endtask

    // Reference: requests at base+64k, pushes are the first LENGTH words from base.
    task automatic check_list(input logic [25:0] base, input int len, input int exp_nreq,
                              input logic exp_priv, input logic exp_fault,
                              input int r0, input int p0, input int d0);
        int bad_a = 0;
        int bad_d = 0;
        int bad_p = 0;
        int nreq = req_log.size() - r0;
        int npush = push_log.size() - p0;
        check("num_requests", 32'(nreq), 32'(exp_nreq));
        for (int k = 0; k < nreq; k++)
            if (req_log[r0 + k] !== base + 26'(64 * k)) bad_a++;
        check("request_addr_errors", 32'(bad_a), 32'd0);
        check("num_pushes", 32'(npush), 32'(len));
        for (int k = 0; k < npush && k < len; k++) begin
            if (push_log[p0 + k] !== mem_word(base + 26'(4 * k))) bad_d++;
            if (push_priv[p0 + k] !== exp_priv) bad_p++;
        end
        check("push_data_errors", 32'(bad_d), 32'd0);
        check("push_priv_errors", 32'(bad_p), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_after", {31'b0, busy}, 32'd0);
        check("remaining_after", {16'b0, remaining}, 32'd0);
        check("fault", {31'b0, fault}, {31'b0, exp_fault});
    endtask

    typedef struct {
        logic [25:0] base;
        logic [15:0] len;
        int          nreq;
        logic [25:0] last_req;
        logic        privw;
        logic        privok;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int r0, p0, d0, c;
        logic [25:0] rb;
        logic [15:0] rl;
        logic        rpw, rpo;

        vecs[0] = '{26'h0000100, 16'd5,  1, 26'h0000100, 1'b1, 1'b1};
        vecs[1] = '{26'h0000100, 16'd40, 3, 26'h0000180, 1'b0, 1'b1};
        vecs[2] = '{26'h3FFFFC0, 16'd32, 2, 26'h0000000, 1'b1, 1'b0};
        vecs[3] = '{26'h0002000, 16'd17, 2, 26'h0002040, 1'b0, 1'b0};
        vecs[4] = '{26'h0000040, 16'd16, 1, 26'h0000040, 1'b1, 1'b1};
        vecs[5] = '{26'h0012344, 16'd0,  0, 26'h0000000, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_remaining", {16'b0, remaining}, 32'd0);
        check("reset_request", {31'b0, sdram_request}, 32'd0);
        check("reset_address", {6'b0, sdram_address}, 32'd0);
        check("reset_valid", {31'b0, blit_valid}, 32'd0);
        check("reset_fault", {31'b0, fault}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LENGTH=0: done exactly one cycle after the write, never busy, no request.
        r0 = req_log.size();
        wr_reg(2'd1, 32'd0, 1'b0);
        check("len0_done_next_cycle", {31'b0, done}, 32'd1);
        check("len0_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("len0_done_single", {31'b0, done}, 32'd0);
        repeat (5) @(negedge clk);
        check("len0_no_request", 32'(req_log.size() - r0), 32'd0);

        foreach (vecs[i]) begin
            r0 = req_log.size(); p0 = push_log.size(); d0 = done_cnt;
            start_list(vecs[i].base, vecs[i].len, vecs[i].privw, vecs[i].privok);
            wait_done(d0, 3000);
            check_list(vecs[i].base, int'(vecs[i].len), vecs[i].nreq,
                       vecs[i].privw & vecs[i].privok, 1'b0, r0, p0, d0);
            if (req_log.size() > r0)
                check("last_request_addr", {6'b0, req_log[req_log.size() - 1]},
                      {6'b0, vecs[i].last_req});
        end

        // Blitter full: local FIFO fills after two bursts and fetching stalls.
        slots_mode = 1;
        r0 = req_log.size(); p0 = push_log.size(); d0 = done_cnt;
        start_list(26'h0001000, 16'd64, 1'b0, 1'b0);
        repeat (400) @(negedge clk);
        check("throttle_no_push", 32'(push_log.size() - p0), 32'd0);
        check("throttle_requests", 32'(req_log.size() - r0), 32'd2);
        check("throttle_busy", {31'b0, busy}, 32'd1);
        slots_mode = 0;
        wait_done(d0, 3000);
        check_list(26'h0001000, 64, 4, 1'b0, 1'b0, r0, p0, d0);

        // Abort in the middle of the second burst.
        r0 = req_log.size(); d0 = done_cnt;
        start_list(26'h0008000, 16'd64, 1'b0, 1'b0);
        c = 0;
        while (!((req_log.size() - r0) == 2 && burst_word >= 6) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("abort_reached_burst2", 32'(c < 2000), 32'd1);
        wr_reg(2'd2, 32'd1, 1'b0);
        p0 = push_log.size();
        c = 0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("abort_busy_falls", {31'b0, busy}, 32'd0);
        check("abort_remaining", {16'b0, remaining}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_push_after", 32'(push_log.size() - p0), 32'd0);
        check("abort_no_new_request", 32'(req_log.size() - r0), 32'd2);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_no_fault", {31'b0, fault}, 32'd0);

        // Run after an abort must start from a clean FIFO.
        r0 = req_log.size(); p0 = push_log.size(); d0 = done_cnt;
        start_list(26'h0000200, 16'd20, 1'b0, 1'b0);
        wait_done(d0, 3000);
        check_list(26'h0000200, 20, 2, 1'b0, 1'b0, r0, p0, d0);

        // raddress off by 4 on the fourth word: sticky fault, data unaffected.
        corrupt_at = word_ctr + 3;
        r0 = req_log.size(); p0 = push_log.size(); d0 = done_cnt;
        start_list(26'h0000500, 16'd5, 1'b0, 1'b0);
        wait_done(d0, 3000);
        check_list(26'h0000500, 5, 1, 1'b0, 1'b1, r0, p0, d0);
        corrupt_at = -1;
        r0 = req_log.size(); p0 = push_log.size(); d0 = done_cnt;
        start_list(26'h0000600, 16'd3, 1'b0, 1'b0);
        wait_done(d0, 3000);
        check_list(26'h0000600, 3, 1, 1'b0, 1'b1, r0, p0, d0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("fault_cleared_by_reset", {31'b0, fault}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Random lists with random throttling, checked against the reference.
        slots_mode = 2;
        for (int it = 0; it < 10; it++) begin
            rb  = 26'($urandom()) & 26'h3FFFFFC;
            rl  = 16'($urandom_range(0, 70));
            rpw = 1'($urandom_range(0, 1));
            rpo = 1'($urandom_range(0, 1));
            r0 = req_log.size(); p0 = push_log.size(); d0 = done_cnt;
            start_list(rb, rl, rpw, rpo);
            wait_done(d0, 6000);
            check_list(rb, int'(rl), (int'(rl) + BW - 1) / BW, rpw & rpo, 1'b0, r0, p0, d0);
        end
        slots_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
